ee457_mem_dma: RTL
==================

// Module: ee457_mem_dma
// PURPOSE
//  Initiator side of the 256x32 data-memory port: a block-copy engine that drives addr/wdata/memread/memwrite.
//  Accepts a start command (src, dst, len), copies len words src->dst one word at a time and reports done.
//  Accumulates a 32-bit checksum of the copied words.
//  Sits beside the pipeline as a second bus master; the arbitration mux is outside this block.
// PARAMETERS
//  ADDR_SIZE  8   word-address width; memory depth is 2**ADDR_SIZE
//  DATA_SIZE  32  data word width
//  LEN_SIZE   9   length width (ADDR_SIZE+1), so a full 256-word copy is expressible
// PORTS
//  clk       in   1          single clock, rising edge
//  rst_n     in   1          asynchronous, active-low reset
//  start     in   1          command strobe; sampled only in IDLE
//  src       in   ADDR_SIZE  source base word address
//  dst       in   ADDR_SIZE  destination base word address
//  len       in   LEN_SIZE   word count, 0..256
//  busy      out  1          high in READ/WRITE
//  done      out  1          one-cycle pulse at end of a command
//  checksum  out  DATA_SIZE  sum mod 2**32 of copied words; held after done
//  addr      out  ADDR_SIZE  memory address
//  wdata     out  DATA_SIZE  memory write data
//  memread   out  1          memory read enable; rdata is combinational while high
//  memwrite  out  1          memory write enable; the write commits at the next rising clk
//  rdata     in   DATA_SIZE  memory read data; it is Z when memread=0 and is never sampled then
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE. busy, done, memread, memwrite=0. addr, wdata, checksum, internal counters=0.
//  States: IDLE, READ, WRITE, DONE.
//   IDLE: with start=1, latch src, dst, len; clear checksum and the index i.
//     len==0 -> DONE. Otherwise -> READ.
//   READ: memread=1, addr=src+i. At the clock edge, rdata goes into the buffer reg and is added to checksum -> WRITE.
//   WRITE: memwrite=1, addr=dst+i, wdata=buffer. At the clock edge i++.
//     If i+1==len -> DONE, else -> READ.
//   DONE: done=1 for exactly one cycle; busy=0 -> IDLE.
//  Outputs are registered from state. memread and memwrite are never both high.
//  In IDLE/DONE, addr and wdata are driven to 0.
//  Timing: start is accepted at edge k. READ/WRITE occupy cycles k+1..k+2N and done is high in cycle k+2N+1.
//    len=0: done is high in cycle k+1 and no memory access occurs.
//  Address arithmetic is mod 2**ADDR_SIZE: src+i and dst+i wrap 0xFF->0x00. i counts to len using LEN_SIZE bits.
//  Copy order is strictly ascending. With overlap dst in (src, src+len) the source is overwritten before it is read.
//    This forward-replication result is the defined behaviour, not an error.
//  start while not IDLE (busy or DONE) is ignored, and the command inputs are not re-sampled.
//  Checksum wraps mod 2**32. It is valid from the done cycle until the next accepted start.
//  Reset mid-copy: immediate return to IDLE with memread=memwrite=0.
//    Words already written stay written and no done is pulsed.
// STRUCTURE
//  Shared package ee457_dma_pkg holds:
//    state encoding localparams (IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3)
//    the ADDR_SIZE/DATA_SIZE defaults
//  Single flat module; no sub-module is warranted (FSM + index counter + buffer + accumulator).
//  The bench pairs it with the team's ee457_mem (memread-gated combinational read, posedge write).
// TESTING
//  T1 reset: assert rst_n=0 mid-READ of a 4-word copy -> memread/memwrite/busy/done drop immediately.
//    After release: IDLE, and no done pulse.
//  T2 basic: mem[0x10..0x13]={1,2,3,4}, start src=0x10 dst=0x80 len=4.
//    Required: mem[0x80..0x83]={1,2,3,4}; done in cycle k+9; checksum=0x0000000A.
//  T3 zero length: start len=0 -> done in cycle k+1; memread/memwrite never asserted; checksum=0.
//  T4 wrap: src=0xFE dst=0x40 len=4 -> reads at FE,FF,00,01 and writes at 40..43.
//    Also checksum with mem[FE..01] all 0xFFFFFFFF: result 0xFFFFFFFC (mod 2**32 wrap).
//  T5 overlap: mem[0x20]=0xA5, start src=0x20 dst=0x21 len=3 -> mem[0x21..0x23]=0xA5 (forward replication).
//  T6 busy/full: start len=256 src=0 dst=0; pulse start again at cycle k+5 -> second start ignored.
//    Required: done in cycle k+513 exactly once; memory contents unchanged.

Source files
------------

// File: rtl/ee457_dma_pkg.sv
// Shared definitions for the ee457 data-memory block-copy engine:
// FSM state encoding and default bus widths.
package ee457_dma_pkg;

  localparam int ADDR_SIZE_DEF = 8;
  localparam int DATA_SIZE_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

endpackage

// File: rtl/ee457_mem_dma.sv
// Block-copy bus master for the 256x32 data memory: copies len words src->dst
// in ascending order, one read/write pair per word, and sums the copied words.
module ee457_mem_dma
  import ee457_dma_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int LEN_SIZE  = ADDR_SIZE + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] src,
  input  logic [ADDR_SIZE-1:0] dst,
  input  logic [LEN_SIZE-1:0]  len,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_SIZE-1:0] checksum,
  output logic [ADDR_SIZE-1:0] addr,
  output logic [DATA_SIZE-1:0] wdata,
  output logic                 memread,
  output logic                 memwrite,
  input  logic [DATA_SIZE-1:0] rdata
);

  dma_state_t           state, nxt_state;
  logic [ADDR_SIZE-1:0] src_q, dst_q, nxt_src, nxt_dst;
  logic [LEN_SIZE-1:0]  len_q, nxt_len;
  logic [LEN_SIZE-1:0]  idx, nxt_idx;
  logic [DATA_SIZE-1:0] nxt_checksum, nxt_wdata;
  logic [ADDR_SIZE-1:0] nxt_addr;
  logic                 nxt_busy, nxt_done, nxt_memread, nxt_memwrite;

  // All outputs are registered: the comb block computes the values they take
  // in the next state, so addr/memread are stable for the whole cycle.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    nxt_state    = state;
    nxt_src      = src_q;
    nxt_dst      = dst_q;
    nxt_len      = len_q;
    nxt_idx      = idx;
    nxt_checksum = checksum;
    nxt_busy     = 1'b0;
    nxt_done     = 1'b0;
    nxt_memread  = 1'b0;
    nxt_memwrite = 1'b0;
    nxt_addr     = '0;
    nxt_wdata    = '0;

    case (state)
      IDLE: begin
        if (start) begin
          nxt_src      = src;
          nxt_dst      = dst;
          nxt_len      = len;
          nxt_idx      = '0;
          nxt_checksum = '0;
          if (len == '0) begin
            nxt_state = DONE;
            nxt_done  = 1'b1;
          end else begin
            nxt_state   = READ;
            nxt_busy    = 1'b1;
            nxt_memread = 1'b1;
            nxt_addr    = src;
          end
        end
      end

      READ: begin
        // rdata is only valid here, while memread is high; it becomes the
        // write buffer and feeds the accumulator.
        nxt_checksum = checksum + rdata;
        nxt_state    = WRITE;
        nxt_busy     = 1'b1;
        nxt_memwrite = 1'b1;
        nxt_addr     = dst_q + idx[ADDR_SIZE-1:0];
        nxt_wdata    = rdata;
      end

      WRITE: begin
        nxt_idx = idx + 1'b1;
        if (nxt_idx == len_q) begin
          nxt_state = DONE;
          nxt_done  = 1'b1;
        end else begin
          nxt_state   = READ;
          nxt_busy    = 1'b1;
          nxt_memread = 1'b1;
          nxt_addr    = src_q + nxt_idx[ADDR_SIZE-1:0];
        end
      end

      DONE: begin
        nxt_state = IDLE;
      end

      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      idx      <= '0;
      checksum <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      memread  <= 1'b0;
      memwrite <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= nxt_state;
      src_q    <= nxt_src;
      dst_q    <= nxt_dst;
      len_q    <= nxt_len;
      idx      <= nxt_idx;
      checksum <= nxt_checksum;
      busy     <= nxt_busy;
      done     <= nxt_done;
      memread  <= nxt_memread;
      memwrite <= nxt_memwrite;
      addr     <= nxt_addr;
      wdata    <= nxt_wdata;
    end
  end

endmodule
